tile_noc_inject_arb: RTL and testbench

- Per-tile injection arbiter in front of one source port of the tile mesh NoC.
- Shares that single injection port between NUM_REQ local requesters (e.g. task unit, commit queue, undo-log writer).
- Round-robin arbitration with bounded burst hold.
- Registered output stage with a valid/ready handshake toward the NoC; each beat carries payload plus destination tile id.

---
 rtl/tile_noc_inject_arb.sv | 183 ++++++++++++++++++
 tb/tb_tile_noc_inject_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_noc_inject_arb.sv
// tile_noc_inject_arb
//   Per-tile injection arbiter in front of one source port of the tile mesh NoC.
//   NUM_REQ local requesters share the injection port. Arbitration is
//   round-robin, and the current owner may keep the port for up to MAX_BURST
//   consecutive beats. Beats leave through a registered valid/ready stage.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   s_wvalid/s_wready    per-requester handshake; s_wready is one-hot or zero
//   s_wdata/s_port       per-requester payload and destination tile id
//   m_wvalid/m_wready    handshake toward the NoC injection port
//   m_wdata/m_port       registered payload and destination tile id
//   m_src                index of the requester that sourced the current beat
//   stat_sel             requester whose counters are shown (stats build only)
//   stat_beats           registered beat count of stat_sel (stats build only)
//   stat_stall           registered stall count of stat_sel (stats build only)
//
// Optional feature: define TILE_NOC_ARB_STATS_EN to add per-requester
// saturating beat and stall counters.
module tile_noc_inject_arb #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TILE_ID_WIDTH = 4,
  parameter int MAX_BURST     = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NUM_REQ-1:0]                     s_wvalid,
  output logic [NUM_REQ-1:0]                     s_wready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     s_wdata,
  input  logic [NUM_REQ-1:0][TILE_ID_WIDTH-1:0]  s_port,
  output logic                                   m_wvalid,
  input  logic                                   m_wready,
  output logic [DATA_WIDTH-1:0]                  m_wdata,
  output logic [TILE_ID_WIDTH-1:0]               m_port,
  output logic [$clog2(NUM_REQ)-1:0]             m_src
`ifdef TILE_NOC_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0]             stat_sel,
  output logic [31:0]                            stat_beats,
  output logic [31:0]                            stat_stall
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
  logic [IDX_W-1:0]   grant;
  logic               can_load;
  logic               keep_owner;
  logic               fire;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // First valid requester at or after start, wrapping modulo NUM_REQ.
  // Scanning from the far end lets the closest hit overwrite the others.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] pick;
    int               s;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(start) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (vld[s]) pick = IDX_W'(s);
    end
    return pick;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  // Grant selection and next-state logic
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    s_wready      = '0;

    can_load   = !m_wvalid || m_wready;
    keep_owner = (state == BURST) && s_wvalid[owner] &&
                 (burst_cnt < CNT_W'(MAX_BURST));

    if (state == IDLE)   grant = rr_pick(s_wvalid, rr_ptr);
    else if (keep_owner) grant = owner;
    else                 grant = rr_pick(s_wvalid, idx_inc(owner));

    fire = can_load && s_wvalid[grant];
    if (rstn && fire) s_wready[grant] = 1'b1;

    if (can_load) begin
      if (fire) begin
        state_nxt = BURST;
        if (keep_owner) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end else begin
          // Rotating away, or re-granting a saturated owner with nobody else
          // waiting, both start a fresh burst.
          owner_nxt     = grant;
          burst_cnt_nxt = CNT_W'(1);
        end
      end else begin
        state_nxt     = IDLE;
        rr_ptr_nxt    = idx_inc(owner);
        burst_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Output stage: registered beat toward the NoC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_wvalid <= 1'b0;
      m_wdata  <= '0;
      m_port   <= '0;
      m_src    <= '0;
    end else if (can_load) begin
      if (fire) begin
        m_wvalid <= 1'b1;
        m_wdata  <= s_wdata[grant];
        m_port   <= s_port[grant];
        m_src    <= grant;
      end else begin
        m_wvalid <= 1'b0;
      end
    end
  end

`ifdef TILE_NOC_ARB_STATS_EN
  logic [31:0] beats_cnt [NUM_REQ];
  logic [31:0] stall_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beats_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire && (int'(grant) == i)) beats_cnt[i] <= sat_inc(beats_cnt[i]);
        if (s_wvalid[i] && !s_wready[i]) stall_cnt[i] <= sat_inc(stall_cnt[i]);
      end
    end
  end

  // Stats read stage: one-cycle registered view of the selected counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      stat_beats <= beats_cnt[stat_sel];
      stat_stall <= stall_cnt[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_tile_noc_inject_arb.sv
// Testbench for tile_noc_inject_arb: randomized requesters, a behavioural
// arbitration model feeding a scoreboard, and an independent output monitor.
module tb_tile_noc_inject_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int MB = 4;

  logic                   clk;
  logic                   rstn;
  logic [N-1:0]           s_wvalid;
  logic [N-1:0]           s_wready;
  logic [N-1:0][DW-1:0]   s_wdata;
  logic [N-1:0][TW-1:0]   s_port;
  logic                   m_wvalid;
  logic                   m_wready;
  logic [DW-1:0]          m_wdata;
  logic [TW-1:0]          m_port;
  logic [1:0]             m_src;
`ifdef TILE_NOC_ARB_STATS_EN
  logic [1:0]             stat_sel;
  logic [31:0]            stat_beats;
  logic [31:0]            stat_stall;
  int                     beats_m [N];
  int                     stall_m [N];
`endif

  tile_noc_inject_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .TILE_ID_WIDTH(TW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_port(s_port),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_port(m_port),
    .m_src(m_src)
`ifdef TILE_NOC_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] p;
    logic [1:0]    s;
  } beat_t;

  beat_t sb [$];
  int    checks;
  int    failures;

  // requester side
  logic          pend  [N];
  logic [DW-1:0] pdata [N];
  logic [TW-1:0] pport [N];
  int            waitn [N];

  // reference model: output-register occupancy and burst bookkeeping
  logic mv;
  int   owner;
  int   blen;
  int   rrs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int s);
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    mv = 1'b0; owner = 0; blen = 0; rrs = 0;
    for (int i = 0; i < N; i++) begin
      waitn[i] = 0;
`ifdef TILE_NOC_ARB_STATS_EN
      beats_m[i] = 0;
      stall_m[i] = 0;
`endif
    end
  endtask

  // Evaluated mid-cycle, with inputs settled, for the coming clock edge.
  task automatic model_step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic         cl;
    int           g;
    v = s_wvalid;
    chk("m_wvalid", 64'(m_wvalid), 64'(mv));
    cl = !mv || m_wready;
    if (blen > 0 && blen < MB && v[owner]) g = owner;
    else g = first_from(v, (blen > 0) ? (owner + 1) % N : rrs);
    exp_rdy = '0;
    if (cl && g >= 0) exp_rdy[g] = 1'b1;
    chk("s_wready", 64'(s_wready), 64'(exp_rdy));

    for (int i = 0; i < N; i++) begin
      if (s_wready[i]) begin
        chk("fair_wait_le_12", 64'(waitn[i] <= (N - 1) * MB), 64'd1);
        waitn[i] = 0;
      end else if (v[i] && s_wready != '0) begin
        waitn[i]++;
      end
`ifdef TILE_NOC_ARB_STATS_EN
      if (v[i] && !exp_rdy[i]) stall_m[i]++;
`endif
    end

    if (cl) begin
      if (g >= 0) begin
        sb.push_back('{d: pdata[g], p: pport[g], s: 2'(g)});
        pend[g] = 1'b0;
`ifdef TILE_NOC_ARB_STATS_EN
        beats_m[g]++;
`endif
        if (g == owner && blen > 0 && blen < MB) blen++;
        else begin
          owner = g;
          blen  = 1;
        end
        mv = 1'b1;
      end else begin
        mv   = 1'b0;
        rrs  = (owner + 1) % N;
        blen = 0;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_wvalid[i] = pend[i];
      s_wdata[i]  = pdata[i];
      s_port[i]   = pport[i];
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle(input int dens, input int rdy);
    m_wready = ($urandom_range(99) < rdy);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < dens) begin
        pend[i]  = 1'b1;
        pdata[i] = $urandom;
        pport[i] = TW'($urandom);
      end
    end
    drive_inputs();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks accepted beats against the scoreboard and that a
  // stalled beat is held unchanged.
  initial begin
    beat_t e;
    logic          have_prev;
    logic [DW-1:0] prev_d;
    logic [TW-1:0] prev_p;
    logic [1:0]    prev_s;
    have_prev = 1'b0;
    prev_d = '0; prev_p = '0; prev_s = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          chk("hold_valid", 64'(m_wvalid), 64'd1);
          chk("hold_data", 64'(m_wdata), 64'(prev_d));
          chk("hold_port", 64'(m_port), 64'(prev_p));
          chk("hold_src", 64'(m_src), 64'(prev_s));
        end
        have_prev = m_wvalid && !m_wready;
        prev_d = m_wdata; prev_p = m_port; prev_s = m_src;
        if (m_wvalid && m_wready) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty_on_accept", 64'd0, 64'd1);
          end else begin
            e = sb.pop_front();
            chk("beat_data", 64'(m_wdata), 64'(e.d));
            chk("beat_port", 64'(m_port), 64'(e.p));
            chk("beat_src", 64'(m_src), 64'(e.s));
          end
        end
      end
    end
  end

  initial begin
    int dens_t [4];
    int rdy_t  [4];
    int tries;
    checks = 0; failures = 0;
    dens_t = '{100, 60, 20, 80};
    rdy_t  = '{100, 70, 50, 20};
    rstn = 1'b0;
    m_wready = 1'b1;
`ifdef TILE_NOC_ARB_STATS_EN
    stat_sel = '0;
`endif
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pdata[i] = $urandom; pport[i] = TW'($urandom);
    end
    drive_inputs();
    model_reset();

    #3;
    chk("rst_s_wready", 64'(s_wready), 64'd0);
    chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("rst_m_port", 64'(m_port), 64'd0);
    chk("rst_m_src", 64'(m_src), 64'd0);

    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 600; n++) cycle(dens_t[ph], rdy_t[ph]);

      if (ph == 1) begin
        // Reset while a beat is held in the output register mid-burst.
        tries = 0;
        do begin
          cycle(100, 100);
          tries++;
        end while (!(mv && blen > 1) && tries < 50);
        chk("midrst_reached_burst", 64'(mv && blen > 1), 64'd1);
        chk("midrst_pre_valid", 64'(m_wvalid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_m_wvalid", 64'(m_wvalid), 64'd0);
        chk("midrst_s_wready", 64'(s_wready), 64'd0);
        sb.delete();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
      end
    end

    for (int n = 0; n < 40; n++) cycle(0, 100);
    chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef TILE_NOC_ARB_STATS_EN
    s_wvalid = '0;
    for (int i = 0; i < N; i++) begin
      stat_sel = 2'(i);
      @(posedge clk); #1;
      chk("stat_beats", 64'(stat_beats), 64'(beats_m[i]));
      chk("stat_stall", 64'(stat_stall), 64'(stall_m[i]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
